// File: rtl/video_timing_if.sv
// video_timing_if: run control in, pixel strobe, positions and raster flags out.
interface video_timing_if #(
    parameter int POS_WIDTH   = 10,
    parameter int FRAME_WIDTH = 8
);
    logic                   i_run;
    logic                   o_pix_en;
    logic [POS_WIDTH-1:0]   o_hpos;
    logic [POS_WIDTH-1:0]   o_vpos;
    logic                   o_hsync;
    logic                   o_vsync;
    logic                   o_hblank;
    logic                   o_vblank;
    logic                   o_visible;
    logic                   o_border;
    logic                   o_line_start;
    logic                   o_frame_start;
    logic [FRAME_WIDTH-1:0] o_frame_count;

    modport master (
        input  i_run,
        output o_pix_en, o_hpos, o_vpos, o_hsync, o_vsync, o_hblank, o_vblank,
               o_visible, o_border, o_line_start, o_frame_start, o_frame_count
    );

    modport slave (
        output i_run,
        input  o_pix_en, o_hpos, o_vpos, o_hsync, o_vsync, o_hblank, o_vblank,
               o_visible, o_border, o_line_start, o_frame_start, o_frame_count
    );
endinterface

// File: rtl/video_timing_generator.sv
// video_timing_generator: raster timing with pixel-enable divider, registered
// positions/flags decoded from next-state counters, and a frame counter.
module video_timing_generator #(
    parameter int H_VISIBLE        = 640,
    parameter int H_RIGHT_BORDER   = 8,
    parameter int H_FRONT_PORCH    = 8,
    parameter int H_SYNC_TIME      = 96,
    parameter int H_BACK_PORCH     = 40,
    parameter int H_LEFT_BORDER    = 8,
    parameter int V_VISIBLE        = 480,
    parameter int V_BOTTOM_BORDER  = 8,
    parameter int V_FRONT_PORCH    = 2,
    parameter int V_SYNC_TIME      = 2,
    parameter int V_BACK_PORCH     = 25,
    parameter int V_TOP_BORDER     = 8,
    parameter int HSYNC_ACTIVE_LOW = 1,
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int CLK_DIV          = 1,
    parameter int POS_WIDTH        = 10,
    parameter int FRAME_WIDTH      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    video_timing_if.master vt
);
    localparam int H_TOTAL = H_VISIBLE + H_RIGHT_BORDER + H_FRONT_PORCH + H_SYNC_TIME
                           + H_BACK_PORCH + H_LEFT_BORDER;
    localparam int V_TOTAL = V_VISIBLE + V_BOTTOM_BORDER + V_FRONT_PORCH + V_SYNC_TIME
                           + V_BACK_PORCH + V_TOP_BORDER;
    localparam int H_SYNC_START = H_VISIBLE + H_RIGHT_BORDER + H_FRONT_PORCH;
    localparam int V_SYNC_START = V_VISIBLE + V_BOTTOM_BORDER + V_FRONT_PORCH;
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_WIDTH-1:0] H_LAST   = POS_WIDTH'(H_TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] V_LAST   = POS_WIDTH'(V_TOTAL - 1);
    localparam logic HS_LOW = HSYNC_ACTIVE_LOW != 0;
    localparam logic VS_LOW = VSYNC_ACTIVE_LOW != 0;

    if (H_VISIBLE < 1 || V_VISIBLE < 1 || H_SYNC_TIME < 1 || V_SYNC_TIME < 1 || CLK_DIV < 1)
    begin : g_bad_cfg
        $error("video_timing_generator: illegal timing parameters");
    end

    logic [DIV_W-1:0]       div_q, div_d;
    logic [POS_WIDTH-1:0]   hpos_q, hpos_d, vpos_q, vpos_d;
    logic [FRAME_WIDTH-1:0] frame_q, frame_d;
    logic                   pix_en, h_wrap, v_wrap;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    logic                   hblank_q, hblank_d, vblank_q, vblank_d;
    logic                   visible_q, visible_d, border_q, border_d;
    logic                   line_start_q, line_start_d, frame_start_q, frame_start_d;
    int                     hp, vp;

    always_comb begin
        pix_en   = i_rst_n & vt.i_run & (div_q == DIV_LAST);
        div_d    = vt.i_run ? (div_q == DIV_LAST ? '0 : div_q + 1'b1) : div_q;
        h_wrap   = hpos_q == H_LAST;
        v_wrap   = vpos_q == V_LAST;
        hpos_d   = pix_en ? (h_wrap ? '0 : hpos_q + 1'b1) : hpos_q;
        vpos_d   = (pix_en & h_wrap) ? (v_wrap ? '0 : vpos_q + 1'b1) : vpos_q;
        frame_d  = frame_q + FRAME_WIDTH'(pix_en & h_wrap & v_wrap);
        // Flags decode the next-state position so they line up with it once registered.
        hp       = int'(hpos_d);
        vp       = int'(vpos_d);
        hblank_d = hp >= H_VISIBLE;
        vblank_d = vp >= V_VISIBLE;
        visible_d = !hblank_d && !vblank_d;
        border_d = (hp < H_VISIBLE + H_RIGHT_BORDER || hp >= H_TOTAL - H_LEFT_BORDER)
                && (vp < V_VISIBLE + V_BOTTOM_BORDER || vp >= V_TOTAL - V_TOP_BORDER)
                && !visible_d;
        hsync_d  = (hp >= H_SYNC_START && hp < H_SYNC_START + H_SYNC_TIME) ^ HS_LOW;
        vsync_d  = (vp >= V_SYNC_START && vp < V_SYNC_START + V_SYNC_TIME) ^ VS_LOW;
        line_start_d  = hpos_d == '0;
        frame_start_d = line_start_d && vpos_d == '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q         <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_q       <= '0;
            hsync_q       <= HS_LOW;
            vsync_q       <= VS_LOW;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            visible_q     <= 1'b1;
            border_q      <= 1'b0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            div_q         <= div_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_q       <= frame_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            visible_q     <= visible_d;
            border_q      <= border_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vt.o_pix_en      = pix_en;
    assign vt.o_hpos        = hpos_q;
    assign vt.o_vpos        = vpos_q;
    assign vt.o_hsync       = hsync_q;
    assign vt.o_vsync       = vsync_q;
    assign vt.o_hblank      = hblank_q;
    assign vt.o_vblank      = vblank_q;
    assign vt.o_visible     = visible_q;
    assign vt.o_border      = border_q;
    assign vt.o_line_start  = line_start_q;
    assign vt.o_frame_start = frame_start_q;
    assign vt.o_frame_count = frame_q;
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: three small-raster instances (div 1/3/2, both sync
// polarities) checked every cycle against an arithmetic model of run-cycle count.
module tb_video_timing_generator;
    localparam int HT = 20;
    localparam int VT = 10;
    localparam int HLEN[6] = '{10, 1, 2, 4, 2, 1};
    localparam int VLEN[6] = '{3, 1, 2, 1, 2, 1};

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    int   r;
    int   n_checks = 0;
    int   n_fails = 0;
    bit   found;

    always #5 clk = ~clk;

    video_timing_if #(.POS_WIDTH(10), .FRAME_WIDTH(8)) if_a ();
    video_timing_if #(.POS_WIDTH(10), .FRAME_WIDTH(8)) if_b ();
    video_timing_if #(.POS_WIDTH(10), .FRAME_WIDTH(8)) if_c ();
    assign if_a.i_run = run;
    assign if_b.i_run = run;
    assign if_c.i_run = run;

    video_timing_generator #(
        .H_VISIBLE(10), .H_RIGHT_BORDER(1), .H_FRONT_PORCH(2), .H_SYNC_TIME(4),
        .H_BACK_PORCH(2), .H_LEFT_BORDER(1), .V_VISIBLE(3), .V_BOTTOM_BORDER(1),
        .V_FRONT_PORCH(2), .V_SYNC_TIME(1), .V_BACK_PORCH(2), .V_TOP_BORDER(1),
        .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1), .CLK_DIV(1)
    ) u_a (.i_clk(clk), .i_rst_n(rst_n), .vt(if_a));

    video_timing_generator #(
        .H_VISIBLE(10), .H_RIGHT_BORDER(1), .H_FRONT_PORCH(2), .H_SYNC_TIME(4),
        .H_BACK_PORCH(2), .H_LEFT_BORDER(1), .V_VISIBLE(3), .V_BOTTOM_BORDER(1),
        .V_FRONT_PORCH(2), .V_SYNC_TIME(1), .V_BACK_PORCH(2), .V_TOP_BORDER(1),
        .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1), .CLK_DIV(3)
    ) u_b (.i_clk(clk), .i_rst_n(rst_n), .vt(if_b));

    video_timing_generator #(
        .H_VISIBLE(10), .H_RIGHT_BORDER(1), .H_FRONT_PORCH(2), .H_SYNC_TIME(4),
        .H_BACK_PORCH(2), .H_LEFT_BORDER(1), .V_VISIBLE(3), .V_BOTTOM_BORDER(1),
        .V_FRONT_PORCH(2), .V_SYNC_TIME(1), .V_BACK_PORCH(2), .V_TOP_BORDER(1),
        .HSYNC_ACTIVE_LOW(0), .VSYNC_ACTIVE_LOW(0), .CLK_DIV(2)
    ) u_c (.i_clk(clk), .i_rst_n(rst_n), .vt(if_c));

    // Count of clock edges on which timing was allowed to advance since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= 0;
        else if (run) r <= r + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int region(input int p, input bit is_v);
        int acc = 0;
        for (int i = 0; i < 6; i++) begin
            acc += is_v ? VLEN[i] : HLEN[i];
            if (p < acc) return i;
        end
        return 6;
    endfunction

    task automatic check_inst(input string nm, input int d, input bit lo, input logic pe,
                              input logic [9:0] hp, input logic [9:0] vp,
                              input logic hs, input logic vs, input logic hb, input logic vb,
                              input logic vis, input logic bor, input logic ls, input logic fs,
                              input logic [7:0] fc);
        int n, eh, ev, hr, vr;
        bit e_vis;
        n  = r / d;
        eh = n % HT;
        ev = (n / HT) % VT;
        hr = region(eh, 1'b0);
        vr = region(ev, 1'b1);
        e_vis = hr == 0 && vr == 0;
        check({nm, ".pix_en"},  32'(pe),  32'(rst_n && run && (r % d == d - 1)));
        check({nm, ".hpos"},    32'(hp),  eh);
        check({nm, ".vpos"},    32'(vp),  ev);
        check({nm, ".hsync"},   32'(hs),  32'((hr == 3) ^ lo));
        check({nm, ".vsync"},   32'(vs),  32'((vr == 3) ^ lo));
        check({nm, ".hblank"},  32'(hb),  32'(hr != 0));
        check({nm, ".vblank"},  32'(vb),  32'(vr != 0));
        check({nm, ".visible"}, 32'(vis), 32'(e_vis));
        check({nm, ".border"},  32'(bor),
              32'((hr inside {0, 1, 5}) && (vr inside {0, 1, 5}) && !e_vis));
        check({nm, ".line_start"},  32'(ls), 32'(eh == 0));
        check({nm, ".frame_start"}, 32'(fs), 32'(eh == 0 && ev == 0));
        check({nm, ".frame_count"}, 32'(fc), (n / (HT * VT)) % 256);
    endtask

    task automatic check_all();
        check_inst("A", 1, 1'b1, if_a.o_pix_en, if_a.o_hpos, if_a.o_vpos, if_a.o_hsync,
                   if_a.o_vsync, if_a.o_hblank, if_a.o_vblank, if_a.o_visible, if_a.o_border,
                   if_a.o_line_start, if_a.o_frame_start, if_a.o_frame_count);
        check_inst("B", 3, 1'b1, if_b.o_pix_en, if_b.o_hpos, if_b.o_vpos, if_b.o_hsync,
                   if_b.o_vsync, if_b.o_hblank, if_b.o_vblank, if_b.o_visible, if_b.o_border,
                   if_b.o_line_start, if_b.o_frame_start, if_b.o_frame_count);
        check_inst("C", 2, 1'b0, if_c.o_pix_en, if_c.o_hpos, if_c.o_vpos, if_c.o_hsync,
                   if_c.o_vsync, if_c.o_hblank, if_c.o_vblank, if_c.o_visible, if_c.o_border,
                   if_c.o_line_start, if_c.o_frame_start, if_c.o_frame_count);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) begin @(negedge clk); check_all(); end
        run = 1'b1;
        repeat (2) begin @(negedge clk); check_all(); end
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            check_all();
            found = if_a.o_hpos == 10'd5 && if_a.o_vpos == 10'd1;
        end
        check("A.reach_5_1", 32'(found), 1);
        run = 1'b0;
        repeat (7) begin
            @(negedge clk);
            check_all();
            check("A.hold_hpos", 32'(if_a.o_hpos), 5);
        end
        run = 1'b1;
        @(negedge clk);
        check_all();
        check("A.resume_hpos", 32'(if_a.o_hpos), 6);
        repeat (700) begin @(negedge clk); check_all(); end
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            check_all();
            found = if_a.o_hpos == 10'd15 && if_a.o_vpos == 10'd7;
        end
        check("A.reach_15_7", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1 check_all();
        check("A.async_hpos", 32'(if_a.o_hpos), 0);
        check("A.async_frame_start", 32'(if_a.o_frame_start), 1);
        repeat (2) begin @(negedge clk); check_all(); end
        rst_n = 1'b1;
        #1 check_all();
        @(negedge clk);
        check_all();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            check_all();
            run = $urandom_range(0, 7) != 0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
